// File: rtl/dwt_pkg.sv
// dwt_pkg: shared constants, state type and helpers for the CDF 5/3 lifting stage.
package dwt_pkg;

  localparam int D_W      = 10;       // detail coefficient width (signed)
  localparam int S_W      = 11;       // smooth coefficient width (signed)
  localparam int A_W      = S_W + 1;  // working width for the update sums
  localparam int H_OFFSET = 128;      // bias that centres H in the unsigned byte

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } lift_state_e;

  // Pointer width needed to address a line of the given length.
  function automatic int pw_of(input int width);
    return $clog2(width);
  endfunction

  // Clamp a signed working value into 0..255.
  function automatic logic [7:0] sat8(input logic signed [A_W-1:0] v);
    logic [7:0] r;
    if (v < 12'sd0) begin
      r = 8'd0;
    end else if (v > 12'sd255) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lift53_core.sv
// lift53_core: combinational predict/update step for one even/odd pair.
// LIFT_SATURATE_EN selects clamping of L/H; otherwise both wrap modulo 256.
module lift53_core
  import dwt_pkg::*;
(
  input  logic [7:0]            e_prev,
  input  logic [7:0]            o_prev,
  input  logic [7:0]            e_next,
  input  logic signed [D_W-1:0] d_prev,
  input  logic                  first,
  output logic signed [D_W-1:0] d_n,
  output logic [7:0]            l,
  output logic [7:0]            h
);

  logic [8:0]            pair_sum_s;
  logic [8:0]            pair_avg_s;
  logic signed [D_W-1:0] d_left_s;
  logic signed [A_W-1:0] upd_sum_s;
  logic signed [A_W-1:0] upd_s;
  logic signed [A_W-1:0] s_s;
  logic signed [A_W-1:0] h_full_s;

  // Predict then update; with no d[n-1] on a line start, d[n] stands in for it.
  always_comb begin
    pair_sum_s = {1'b0, e_prev} + {1'b0, e_next};
    pair_avg_s = pair_sum_s >> 1;
    d_n        = $signed({2'b00, o_prev}) - $signed({1'b0, pair_avg_s});
    if (first) begin
      d_left_s = d_n;
    end else begin
      d_left_s = d_prev;
    end
    upd_sum_s = {{(A_W-D_W){d_left_s[D_W-1]}}, d_left_s}
              + {{(A_W-D_W){d_n[D_W-1]}}, d_n} + 12'sd2;
    upd_s     = upd_sum_s >>> 2;
    s_s       = $signed({4'b0000, e_prev}) + upd_s;
    h_full_s  = {{(A_W-D_W){d_n[D_W-1]}}, d_n} + A_W'(H_OFFSET);
  end

`ifdef LIFT_SATURATE_EN
  // Clamp both coefficients into the unsigned byte range.
  always_comb begin
    l = sat8(s_s);
    h = sat8(h_full_s);
  end
`else
  logic unused_hi_s;
  // Keep only the low byte so out-of-range coefficients wrap modulo 256.
  always_comb begin
    l           = s_s[7:0];
    h           = h_full_s[7:0];
    unused_hi_s = ^{s_s[A_W-1:8], h_full_s[A_W-1:8]};
  end
`endif

endmodule

// File: rtl/lifting53_mac.sv
// lifting53_mac: streaming CDF 5/3 lifting between DWT read and write-back ports.
// One pair is held until its right neighbour arrives; the line's last pair is
// finished in a single FLUSH cycle using the mirrored even sample.
// Optional macro LIFT_SATURATE_EN (see lift53_core) selects L/H clamping.
module lifting53_mac
  import dwt_pkg::*;
#(
  parameter int  WIDTH  = 256,
  parameter int  HEIGHT = 256,
  localparam int PW     = pw_of((WIDTH >= HEIGHT) ? WIDTH : HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   i_pair,
  input  logic          i_valid,
  input  logic [PW-1:0] i_row_column_pointer,
  input  logic [PW-1:0] i_pixel_pointer,
  input  logic [PW:0]   i_line_len,
  output logic [15:0]   o_coeff,
  output logic          o_valid,
  output logic [PW-1:0] o_row_column_pointer,
  output logic [PW-1:0] o_pixel_pointer,
  output logic          o_seq_err
);

  localparam logic [PW:0] PTR_STEP = (PW+1)'(2);

  lift_state_e           state_q, state_d;
  logic [7:0]            e_prev_q, e_prev_d;
  logic [7:0]            o_prev_q, o_prev_d;
  logic signed [D_W-1:0] d_prev_q, d_prev_d;
  logic                  first_q, first_d;
  logic [PW-1:0]         row_q, row_d;
  logic [PW-1:0]         pix_q, pix_d;
  logic [15:0]           coeff_q, coeff_d;
  logic                  valid_q, valid_d;
  logic [PW-1:0]         orow_q, orow_d;
  logic [PW-1:0]         opix_q, opix_d;
  logic                  seq_err_q, seq_err_d;

  logic                  in_last_s;
  logic                  in_zero_s;
  logic                  in_contig_s;
  logic [7:0]            e_next_s;
  logic signed [D_W-1:0] core_d_s;
  logic [7:0]            core_l_s;
  logic [7:0]            core_h_s;

  // Classify the incoming pointer and pick the right-hand even sample.
  always_comb begin
    in_last_s   = ({1'b0, i_pixel_pointer} == (i_line_len - PTR_STEP));
    in_zero_s   = (i_pixel_pointer == {PW{1'b0}});
    in_contig_s = ({1'b0, i_pixel_pointer} == ({1'b0, pix_q} + PTR_STEP));
    if (state_q == FLUSH) begin
      e_next_s = e_prev_q;
    end else begin
      e_next_s = i_pair[15:8];
    end
  end

  lift53_core u_core (
    .e_prev (e_prev_q),
    .o_prev (o_prev_q),
    .e_next (e_next_s),
    .d_prev (d_prev_q),
    .first  (first_q),
    .d_n    (core_d_s),
    .l      (core_l_s),
    .h      (core_h_s)
  );

  // Next state, pending-pair capture and output staging.
  always_comb begin
    state_d   = state_q;
    e_prev_d  = e_prev_q;
    o_prev_d  = o_prev_q;
    d_prev_d  = d_prev_q;
    first_d   = first_q;
    row_d     = row_q;
    pix_d     = pix_q;
    coeff_d   = coeff_q;
    valid_d   = 1'b0;
    orow_d    = orow_q;
    opix_d    = opix_q;
    seq_err_d = seq_err_q;
    case (state_q)
      EMPTY: begin
        if (i_valid) begin
          e_prev_d  = i_pair[15:8];
          o_prev_d  = i_pair[7:0];
          row_d     = i_row_column_pointer;
          pix_d     = i_pixel_pointer;
          first_d   = 1'b1;
          seq_err_d = seq_err_q | ~in_zero_s;
          state_d   = in_last_s ? FLUSH : HOLD;
        end else begin
          state_d = EMPTY;
        end
      end
      HOLD: begin
        if (i_valid) begin
          if (in_contig_s) begin
            coeff_d  = {core_l_s, core_h_s};
            valid_d  = 1'b1;
            orow_d   = row_q;
            opix_d   = pix_q;
            d_prev_d = core_d_s;
            first_d  = 1'b0;
          end else begin
            seq_err_d = 1'b1;
            first_d   = 1'b1;
          end
          e_prev_d = i_pair[15:8];
          o_prev_d = i_pair[7:0];
          row_d    = i_row_column_pointer;
          pix_d    = i_pixel_pointer;
          state_d  = in_last_s ? FLUSH : HOLD;
        end else begin
          state_d = HOLD;
        end
      end
      FLUSH: begin
        coeff_d = {core_l_s, core_h_s};
        valid_d = 1'b1;
        orow_d  = row_q;
        opix_d  = pix_q;
        if (i_valid) begin
          e_prev_d  = i_pair[15:8];
          o_prev_d  = i_pair[7:0];
          row_d     = i_row_column_pointer;
          pix_d     = i_pixel_pointer;
          first_d   = 1'b1;
          seq_err_d = seq_err_q | ~in_zero_s;
          state_d   = in_last_s ? FLUSH : HOLD;
        end else begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      e_prev_q  <= 8'd0;
      o_prev_q  <= 8'd0;
      d_prev_q  <= 10'sd0;
      first_q   <= 1'b0;
      row_q     <= {PW{1'b0}};
      pix_q     <= {PW{1'b0}};
      coeff_q   <= 16'd0;
      valid_q   <= 1'b0;
      orow_q    <= {PW{1'b0}};
      opix_q    <= {PW{1'b0}};
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_prev_q  <= e_prev_d;
      o_prev_q  <= o_prev_d;
      d_prev_q  <= d_prev_d;
      first_q   <= first_d;
      row_q     <= row_d;
      pix_q     <= pix_d;
      coeff_q   <= coeff_d;
      valid_q   <= valid_d;
      orow_q    <= orow_d;
      opix_q    <= opix_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign o_coeff              = coeff_q;
  assign o_valid              = valid_q;
  assign o_row_column_pointer = orow_q;
  assign o_pixel_pointer      = opix_q;
  assign o_seq_err            = seq_err_q;

endmodule

// File: tb/tb_lifting53_mac.sv
// tb_lifting53_mac: randomized and directed stimulus against a per-line
// arithmetic reference; expected outputs are scheduled by cycle number.
module tb_lifting53_mac;

  localparam int WIDTH  = 256;
  localparam int HEIGHT = 256;
  localparam int PW     = $clog2(WIDTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   i_pair;
  logic          i_valid;
  logic [PW-1:0] i_row_column_pointer;
  logic [PW-1:0] i_pixel_pointer;
  logic [PW:0]   i_line_len;
  logic [15:0]   o_coeff;
  logic          o_valid;
  logic [PW-1:0] o_row_column_pointer;
  logic [PW-1:0] o_pixel_pointer;
  logic          o_seq_err;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [31:0] exp_q [int];
  logic        err_exp     = 1'b0;
  int          px    [0:255];
  int          res_l [0:127];
  int          res_h [0:127];

  lifting53_mac #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_pair               (i_pair),
    .i_valid              (i_valid),
    .i_row_column_pointer (i_row_column_pointer),
    .i_pixel_pointer      (i_pixel_pointer),
    .i_line_len           (i_line_len),
    .o_coeff              (o_coeff),
    .o_valid              (o_valid),
    .o_row_column_pointer (o_row_column_pointer),
    .o_pixel_pointer      (o_pixel_pointer),
    .o_seq_err            (o_seq_err)
  );

  always #5 clk = ~clk;

  // Count rising edges; expectations are keyed by this count.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, want);
    end
  endtask

  task automatic check_cycle();
    logic [31:0] e;
    if (exp_q.exists(cyc)) begin
      e = exp_q[cyc];
      check_eq("o_valid", 32'(o_valid), 32'd1);
      check_eq("o_coeff", 32'(o_coeff), 32'(e[31:16]));
      check_eq("o_row", 32'(o_row_column_pointer), 32'(e[15:8]));
      check_eq("o_ptr", 32'(o_pixel_pointer), 32'(e[7:0]));
      exp_q.delete(cyc);
    end else begin
      check_eq("o_valid_idle", 32'(o_valid), 32'd0);
    end
    check_eq("o_seq_err", 32'(o_seq_err), 32'(err_exp));
  endtask

  // Drive one cycle of input at the falling edge, then check after the next rise.
  task automatic tick(input logic v, input logic [15:0] p, input int row, input int ptr);
    i_valid              = v;
    i_pair               = p;
    i_row_column_pointer = PW'(row);
    i_pixel_pointer      = PW'(ptr);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 16'($urandom), 0, 0);
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int to_byte(input int v);
`ifdef LIFT_SATURATE_EN
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
`else
    return ((v % 256) + 256) % 256;
`endif
  endfunction

  // Whole-line reference: symmetric extension at both ends, floor division.
  function automatic void model_line(input int n2);
    int d [0:127];
    int np;
    int en;
    int dm;
    int s;
    np = n2 / 2;
    for (int n = 0; n < np; n++) begin
      en   = (2*n + 2 < n2) ? px[2*n + 2] : px[2*n];
      d[n] = px[2*n + 1] - floor_div(px[2*n] + en, 2);
    end
    for (int n = 0; n < np; n++) begin
      dm       = (n == 0) ? d[0] : d[n - 1];
      s        = px[2*n] + floor_div(dm + d[n] + 2, 4);
      res_l[n] = to_byte(s);
      res_h[n] = to_byte(d[n] + 128);
    end
  endfunction

  function automatic logic [31:0] pack(input int n, input int row);
    return {8'(res_l[n]), 8'(res_h[n]), 8'(row), 8'(2*n)};
  endfunction

  // Stream one line; pair n is due the cycle pair n+1 is taken, the last pair one later.
  task automatic run_line(input int row, input int n2, input int gap_lo, input int gap_hi);
    int np;
    int a;
    int g;
    np = n2 / 2;
    model_line(n2);
    i_line_len = (PW+1)'(n2);
    for (int n = 0; n < np; n++) begin
      if (n > 0) begin
        g = int'($urandom_range(gap_hi, gap_lo));
        idle(g);
      end
      a = cyc + 1;
      if (n > 0) exp_q[a] = pack(n - 1, row);
      if (n == np - 1) exp_q[a + 1] = pack(n, row);
      tick(1'b1, {8'(px[2*n]), 8'(px[2*n + 1])}, row, 2*n);
    end
  endtask

  function automatic int rand_pix();
    int sel;
    sel = int'($urandom_range(3, 0));
    if (sel == 0) return 0;
    if (sel == 1) return 255;
    return int'($urandom_range(255, 0));
  endfunction

  initial begin
    int n2;
    rst                  = 1'b1;
    i_valid              = 1'b0;
    i_pair               = 16'd0;
    i_row_column_pointer = {PW{1'b0}};
    i_pixel_pointer      = {PW{1'b0}};
    i_line_len           = (PW+1)'(4);
    idle(2);
    check_eq("rst_coeff", 32'(o_coeff), 32'd0);
    check_eq("rst_row", 32'(o_row_column_pointer), 32'd0);
    check_eq("rst_ptr", 32'(o_pixel_pointer), 32'd0);
    rst = 1'b0;
    idle(2);

    // 10,20,30,40 on row 5 -> {10,128} then {33,138}
    px[0] = 10; px[1] = 20; px[2] = 30; px[3] = 40;
    run_line(5, 4, 0, 0);
    idle(3);

    // Constant 100 line then a second row back-to-back
    for (int i = 0; i < 8; i++) px[i] = 100;
    run_line(0, 8, 0, 0);
    for (int i = 0; i < 8; i++) px[i] = rand_pix();
    run_line(1, 8, 0, 0);
    idle(3);

    // Single-pair lines back-to-back, exercising both range limits
    px[0] = 0;   px[1] = 255; run_line(7, 2, 0, 0);
    px[0] = 255; px[1] = 0;   run_line(8, 2, 0, 0);
    px[0] = rand_pix(); px[1] = rand_pix(); run_line(9, 2, 0, 0);
    idle(3);

    // Same 4-sample line with a 3-cycle gap between pairs
    px[0] = 10; px[1] = 20; px[2] = 30; px[3] = 40;
    run_line(5, 4, 3, 3);
    idle(3);

    // Random lines, lengths, gaps and line spacing
    for (int ln = 0; ln < 40; ln++) begin
      n2 = 2 * int'($urandom_range(16, 1));
      for (int i = 0; i < n2; i++) px[i] = rand_pix();
      run_line(int'($urandom_range(255, 0)), n2, 0, int'($urandom_range(2, 0)));
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
    end
    idle(3);

    // Pointer skip: flag latches, the dropped pair is never emitted
    i_line_len = (PW+1)'(8);
    tick(1'b1, 16'($urandom), 3, 0);
    err_exp = 1'b1;
    tick(1'b1, 16'($urandom), 3, 4);
    idle(3);

    // Reset mid-line clears everything and discards the pending pair
    rst     = 1'b1;
    err_exp = 1'b0;
    idle(1);
    check_eq("mid_rst_coeff", 32'(o_coeff), 32'd0);
    check_eq("mid_rst_row", 32'(o_row_column_pointer), 32'd0);
    check_eq("mid_rst_ptr", 32'(o_pixel_pointer), 32'd0);
    rst = 1'b0;
    idle(3);
    for (int i = 0; i < 4; i++) px[i] = rand_pix();
    run_line(2, 4, 0, 1);
    idle(3);

    check_eq("leftover_expected", 32'(exp_q.num()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
